// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA priority arbiter.
// The state encoding, command-bit positions and the one-hot helper live here
// so the arbiter and any register-file wrapper agree on them.
package dma_arb_pkg;

    // Largest supported channel count and the index width that covers it
    localparam int MAX_CH   = 16;
    localparam int MAX_CH_W = 4;

    // Bit positions of the arbiter controls inside the legacy command register
    localparam int DREQ_POL_BIT = 6;
    localparam int DACK_POL_BIT = 7;
    localparam int ROT_BIT      = 4;
    localparam int DIS_BIT      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GRANT = 2'd2
    } arb_state_e;

    // One-hot decode of a channel index, sized for the largest configuration
    function automatic logic [MAX_CH-1:0] onehot(input logic [MAX_CH_W-1:0] idx);
        return MAX_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/dma_rot_prio_enc.sv
// Rotating/fixed priority encoder for the DMA arbiter.
// The request vector is rotated so that the highest-priority channel sits at
// bit 0. A plain lowest-set-bit search then runs, and the pointer is added back
// modulo NUM_CH. In fixed mode the pointer is forced to zero.
module dma_rot_prio_enc
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              rot_en,
    output logic              found,
    output logic [CH_W-1:0]   winner
);

    logic [CH_W-1:0]   base;
    logic [CH_W-1:0]   offset;
    logic [NUM_CH-1:0] req_rot;
    logic [CH_W:0]     sum;

    assign base    = rot_en ? ptr : '0;
    assign req_rot = NUM_CH'({req, req} >> base);

    // Lowest set bit of the rotated vector is the offset from the priority pointer
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                found  = 1'b1;
                offset = CH_W'(i);
            end
        end
    end

    // Undo the rotation, wrapping at NUM_CH so non-power-of-two counts work
    always_comb begin
        sum = {1'b0, base} + {1'b0, offset};
        if (sum >= (CH_W+1)'(NUM_CH)) begin
            winner = CH_W'(sum - (CH_W+1)'(NUM_CH));
        end else begin
            winner = CH_W'(sum);
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// NUM_CH-channel DMA priority arbiter with the HRQ/HLDA host handshake.
// It qualifies hardware and software requests and resolves fixed or rotating
// priority. It then holds a registered, non-preemptive grant until the timing
// control block reports service complete.
// Optional sticky request status is enabled by defining DMA_ARB_REQ_STATUS_EN.
module dma_priority_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] sw_req,
    input  logic [NUM_CH-1:0] mask,
    input  logic              dreq_pol,
    input  logic              dack_pol,
    input  logic              rot_en,
    input  logic              ctrl_dis,
    input  logic              HLDA,
    input  logic              svc_done,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grant_valid,
    output logic [CH_W-1:0]   grant_ch,
    output logic [NUM_CH-1:0] req_status,
    input  logic              status_rd
);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [NUM_CH-1:0] dreq_q;
    logic [NUM_CH-1:0] act_req;
    logic              hrq_q;
    logic              grant_valid_q;
    logic [CH_W-1:0]   grant_ch_q;
    logic [CH_W-1:0]   ptr;
    logic              enc_found;
    logic [CH_W-1:0]   enc_winner;
    logic              load_grant;
    logic              advance_ptr;
    logic [NUM_CH-1:0] grant_oh;

    // Single register stage on the raw DREQ lines
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dreq_q <= '0;
        end else begin
            dreq_q <= DREQ;
        end
    end

    // Polarity-corrected, masked hardware requests; software requests bypass the mask
    assign act_req = ((dreq_q ^ {NUM_CH{dreq_pol}}) & ~mask) | sw_req;

    dma_rot_prio_enc #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_prio_enc (
        .req    (act_req),
        .ptr    (ptr),
        .rot_en (rot_en),
        .found  (enc_found),
        .winner (enc_winner)
    );

    // Handshake sequencing: request the bus, latch the winner on HLDA, hold until done or abort
    always_comb begin
        state_nxt   = state;
        load_grant  = 1'b0;
        advance_ptr = 1'b0;
        case (state)
            IDLE: begin
                if (!ctrl_dis && (|act_req)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (!enc_found) begin
                    state_nxt = IDLE;
                end else if (HLDA) begin
                    state_nxt  = GRANT;
                    load_grant = 1'b1;
                end
            end
            GRANT: begin
                if (svc_done) begin
                    state_nxt   = IDLE;
                    advance_ptr = rot_en;
                end else if (!HLDA) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State plus registered HRQ and grant outputs, all derived from the next state
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            hrq_q         <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_ch_q    <= '0;
        end else begin
            state         <= state_nxt;
            hrq_q         <= (state_nxt != IDLE);
            grant_valid_q <= (state_nxt == GRANT);
            if (load_grant) begin
                grant_ch_q <= enc_winner;
            end
        end
    end

    // After a completed service in rotating mode the serviced channel drops to lowest priority
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr <= '0;
        end else if (advance_ptr) begin
            if (grant_ch_q == CH_W'(NUM_CH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_ch_q + CH_W'(1);
            end
        end
    end

    assign grant_oh    = grant_valid_q ? NUM_CH'(onehot(MAX_CH_W'(grant_ch_q))) : '0;
    assign DACK        = dack_pol ? grant_oh : ~grant_oh;
    assign HRQ         = hrq_q;
    assign grant_valid = grant_valid_q;
    assign grant_ch    = grant_ch_q;

`ifdef DMA_ARB_REQ_STATUS_EN
    logic [NUM_CH-1:0] req_status_q;

    // Sticky pending bits; a new request in the read-clear cycle survives the clear
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            req_status_q <= '0;
        end else begin
            req_status_q <= (status_rd ? '0 : req_status_q) | act_req;
        end
    end

    assign req_status = req_status_q;
`else
    logic unused_status_rd;

    assign req_status       = '0;
    assign unused_status_rd = status_rd;
`endif

endmodule
